// File: rtl/rc5_pkg.sv
// Shared RC-5 definitions for the transmit and receive paths.
package rc5_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } rc5_tx_state_t;

  localparam int RC5_FRAME_BITS  = 14;
  localparam int RC5_HALF_BITS   = 28;
  localparam int RC5_ADDR_W      = 5;
  localparam int RC5_CMD_W       = 6;
  localparam int RC5_DEFAULT_GAP = 100;

  // Line level of one Manchester half-bit: a logical 1 is space then mark,
  // a logical 0 is mark then space. The frame is sent MSB first.
  function automatic logic rc5HalfLevel(input logic [RC5_FRAME_BITS-1:0] frame,
                                        input logic [4:0] hidx);
    logic bitVal;
    bitVal = frame[4'd13 - hidx[4:1]];
    return hidx[0] ? bitVal : ~bitVal;
  endfunction

endpackage

// File: rtl/rc5_tick_detect.sv
// Turns the half-bit divider output into a one-cycle tick on each rising edge.
module rc5_tick_detect (
  input  logic clk,
  input  logic rst,
  input  logic clk_div,
  output logic half_tick
);

  logic r_clkDivQ;

  // Remember last cycle's divider level so a rising edge stands out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clkDivQ <= 1'b0;
    end else begin
      r_clkDivQ <= clk_div;
    end
  end

  assign half_tick = clk_div & ~r_clkDivQ;

endmodule

// File: rtl/rc5_manchester_tx.sv
// RC-5 frame encoder: builds the 14-bit frame on request and emits it as a
// Manchester-coded baseband envelope, one half-bit per divider tick, followed
// by an idle gap. Holding the request repeats the frame with the same toggle.
module rc5_manchester_tx
  import rc5_pkg::*;
#(
  parameter int GAP_HALFBITS = RC5_DEFAULT_GAP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_div,
  input  logic                  req,
  input  logic [RC5_ADDR_W-1:0] addr,
  input  logic [RC5_CMD_W-1:0]  cmd,
  output logic                  ir_out,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int GCNT_W = (GAP_HALFBITS > 0) ? $clog2(GAP_HALFBITS + 1) : 1;
  localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'(GAP_HALFBITS - 1);
  localparam logic [4:0] HIDX_LAST = 5'(RC5_HALF_BITS - 1);

  if (GAP_HALFBITS < 1) begin : g_gapCheck
    $error("rc5_manchester_tx: GAP_HALFBITS must be at least 1");
  end

  rc5_tx_state_t             r_state;
  logic [RC5_FRAME_BITS-1:0] r_frame;
  logic [4:0]                r_hidx;
  logic [GCNT_W-1:0]         r_gcnt;
  logic                      r_tgl;
  logic                      r_held;
  logic                      r_irOut;
  logic                      r_busy;
  logic                      r_frameDone;

  logic                      w_halfTick;
  logic                      w_tglNext;
  logic [RC5_FRAME_BITS-1:0] w_frameNew;
  logic [4:0]                w_hidxNext;
  logic [GCNT_W-1:0]         w_gcntNext;

  rc5_tick_detect u_tickDetect (
    .clk       (clk),
    .rst       (rst),
    .clk_div   (clk_div),
    .half_tick (w_halfTick)
  );

  // A fresh press flips the toggle bit; a held key keeps it.
  assign w_tglNext  = r_held ? r_tgl : ~r_tgl;
  assign w_frameNew = {1'b1, 1'b1, w_tglNext, addr, cmd};
  assign w_hidxNext = r_hidx + 5'd1;
  assign w_gcntNext = r_gcnt + GCNT_W'(1);

  // Encoder FSM: accept a request, walk the 28 half-bits, then hold the line
  // idle for the gap. Everything advances only on a half-bit tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_frame     <= '0;
      r_hidx      <= '0;
      r_gcnt      <= '0;
      r_tgl       <= 1'b0;
      r_held      <= 1'b0;
      r_irOut     <= 1'b0;
      r_busy      <= 1'b0;
      r_frameDone <= 1'b0;
    end else begin
      r_frameDone <= 1'b0;
      if (w_halfTick) begin
        if (!req) begin
          r_held <= 1'b0;
        end
        case (r_state)
          IDLE: begin
            if (req) begin
              r_tgl   <= w_tglNext;
              r_held  <= 1'b1;
              r_frame <= w_frameNew;
              r_hidx  <= 5'd0;
              r_irOut <= rc5HalfLevel(w_frameNew, 5'd0);
              r_busy  <= 1'b1;
              r_state <= SEND;
            end
          end
          SEND: begin
            if (r_hidx == HIDX_LAST) begin
              r_irOut     <= 1'b0;
              r_frameDone <= 1'b1;
              r_gcnt      <= '0;
              if (GCNT_LAST == '0) begin
                r_busy  <= 1'b0;
                r_state <= IDLE;
              end else begin
                r_state <= GAP;
              end
            end else begin
              r_hidx  <= w_hidxNext;
              r_irOut <= rc5HalfLevel(r_frame, w_hidxNext);
            end
          end
          GAP: begin
            r_irOut <= 1'b0;
            r_gcnt  <= w_gcntNext;
            if (w_gcntNext == GCNT_LAST) begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign ir_out     = r_irOut;
  assign busy       = r_busy;
  assign frame_done = r_frameDone;

endmodule
